mii_rx_framer: RTL and testbench

MII_RX_FRAMER -- requirements
Module: mii_rx_framer

---
 rtl/eth_pkg.sv | 28 ++
 rtl/crc32_d8.sv | 21 ++
 rtl/mii_rx_framer.sv | 150 +++++++++++++++
 tb/tb_mii_rx_framer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: framer state encoding, CRC-32 constants,
// default frame length limits and small helpers.
package eth_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2,
      DROP     = 2'd3
   } state_t;

   localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
   localparam int unsigned MIN_LEN_DEF = 64;
   localparam int unsigned MAX_LEN_DEF = 1518;

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) r[i] = v[31 - i];
      return r;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == '1) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected Ethernet CRC-32 over one byte,
// data consumed LSB first.
module crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   localparam logic [31:0] POLY_REFL = bitrev32(CRC_POLY);

   always_comb begin
      crc_out = crc_in;
      for (int unsigned i = 0; i < 8; i++) begin
         if (crc_out[0] ^ data[i]) crc_out = (crc_out >> 1) ^ POLY_REFL;
         else                      crc_out = crc_out >> 1;
      end
   end

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, assembles nibbles into bytes, checks
// FCS, length and receive errors, and flags each frame good or bad at eof.
module mii_rx_framer
   import eth_pkg::*;
#(
   parameter int unsigned MAX_LEN = MAX_LEN_DEF,
   parameter int unsigned MIN_LEN = MIN_LEN_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  e_rx_d,
   input  logic        e_rx_dv,
   input  logic        e_rx_er,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sof,
   output logic        rx_eof,
   output logic        rx_err,
   output logic [15:0] rx_frame_cnt,
   output logic [15:0] rx_err_cnt
);

   localparam logic [10:0] MIN_L = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L = 11'(MAX_LEN);

   state_t      state;
   logic        toggle;
   logic [3:0]  low_nib;
   logic [7:0]  held;
   logic        have_held;
   logic        sof_pend;
   logic        er_seen;
   logic        ovf;
   logic        ending;
   logic [10:0] byte_cnt;
   logic [31:0] crc;
   logic [31:0] crc_next;
   logic [7:0]  cur_byte;
   logic        frame_bad;

   assign cur_byte = {e_rx_d, low_nib};

   crc32_d8 u_crc (
      .crc_in  (crc),
      .data    (cur_byte),
      .crc_out (crc_next)
   );

   // Register is kept in reflected (shift-right) form; residue is stated unreflected.
   assign frame_bad = (bitrev32(crc) != CRC_RESIDUE) || er_seen || toggle ||
                      (byte_cnt < MIN_L) || ovf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         toggle       <= 1'b0;
         low_nib      <= '0;
         held         <= '0;
         have_held    <= 1'b0;
         sof_pend     <= 1'b0;
         er_seen      <= 1'b0;
         ovf          <= 1'b0;
         ending       <= 1'b0;
         byte_cnt     <= '0;
         crc          <= '1;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_sof       <= 1'b0;
         rx_eof       <= 1'b0;
         rx_err       <= 1'b0;
         rx_frame_cnt <= '0;
         rx_err_cnt   <= '0;
      end else begin
         rx_valid <= 1'b0;
         rx_sof   <= 1'b0;
         rx_eof   <= 1'b0;
         rx_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (e_rx_dv) state <= (e_rx_d == 4'h5) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
               if (!e_rx_dv)              state <= IDLE;
               else if (e_rx_d == 4'hD) begin
                  state     <= DATA;
                  toggle    <= 1'b0;
                  have_held <= 1'b0;
                  sof_pend  <= 1'b1;
                  er_seen   <= 1'b0;
                  ovf       <= 1'b0;
                  ending    <= 1'b0;
                  byte_cnt  <= '0;
                  crc       <= '1;
               end else if (e_rx_d != 4'h5) state <= DROP;
            end
            DATA: begin
               // eof is emitted one cycle after dv falls so it never abuts the previous byte
               if (ending) begin
                  if (have_held) begin
                     rx_valid <= 1'b1;
                     rx_data  <= held;
                     rx_sof   <= sof_pend;
                     rx_eof   <= 1'b1;
                     rx_err   <= frame_bad;
                  end
                  if (frame_bad) rx_err_cnt   <= sat_inc16(rx_err_cnt);
                  else           rx_frame_cnt <= sat_inc16(rx_frame_cnt);
                  if (!e_rx_dv)              state <= IDLE;
                  else if (e_rx_d == 4'h5)   state <= PREAMBLE;
                  else                       state <= DROP;
               end else if (!e_rx_dv) begin
                  ending <= 1'b1;
                  if (e_rx_er) er_seen <= 1'b1;
               end else if (ovf && toggle) begin
                  rx_valid   <= 1'b1;
                  rx_data    <= held;
                  rx_sof     <= sof_pend;
                  rx_eof     <= 1'b1;
                  rx_err     <= 1'b1;
                  rx_err_cnt <= sat_inc16(rx_err_cnt);
                  state      <= DROP;
               end else begin
                  if (e_rx_er) er_seen <= 1'b1;
                  toggle <= ~toggle;
                  if (!toggle) begin
                     low_nib <= e_rx_d;
                  end else begin
                     crc       <= crc_next;
                     byte_cnt  <= byte_cnt + 11'd1;
                     held      <= cur_byte;
                     have_held <= 1'b1;
                     if (have_held) begin
                        rx_valid <= 1'b1;
                        rx_data  <= held;
                        rx_sof   <= sof_pend;
                        sof_pend <= 1'b0;
                     end
                     if (byte_cnt == MAX_L) ovf <= 1'b1;
                  end
               end
            end
            DROP: begin
               if (!e_rx_dv) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mii_rx_framer.sv
// Scoreboard bench for mii_rx_framer: frames are built with a reference FCS,
// expected output bytes queued at send time and popped as rx_valid appears.
module tb_mii_rx_framer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  e_rx_d = '0;
   logic        e_rx_dv = 1'b0;
   logic        e_rx_er = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_sof, rx_eof, rx_err;
   logic [15:0] rx_frame_cnt, rx_err_cnt;

   typedef struct packed {
      logic [7:0] data;
      logic       sof;
      logic       eof;
      logic       err;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] frm[$];
   int         checks = 0;
   int         errors = 0;
   int         ign_eof = 0;
   int         exp_good = 0;
   int         exp_bad = 0;
   bit         ign = 1'b0;
   logic       prev_valid = 1'b0;

   mii_rx_framer #(.MAX_LEN(1518), .MIN_LEN(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .e_rx_d       (e_rx_d),
      .e_rx_dv      (e_rx_dv),
      .e_rx_er      (e_rx_er),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_sof       (rx_sof),
      .rx_eof       (rx_eof),
      .rx_err       (rx_err),
      .rx_frame_cnt (rx_frame_cnt),
      .rx_err_cnt   (rx_err_cnt)
   );

   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rx_eof) check("err_noeof", {31'd0, rx_err}, 32'd0);
      if (rx_valid) begin
         check("b2b", {31'd0, prev_valid}, 32'd0);
         if (ign) begin
            if (rx_eof) ign_eof++;
         end else if (sb.size() == 0) begin
            check("spurious", {31'd0, rx_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("data", {24'd0, rx_data}, {24'd0, e.data});
            check("sof",  {31'd0, rx_sof},  {31'd0, e.sof});
            check("eof",  {31'd0, rx_eof},  {31'd0, e.eof});
            check("err",  {31'd0, rx_err},  {31'd0, e.err});
         end
      end
      prev_valid <= rx_valid;
   end

   task automatic build_frame(input int n);
      logic [31:0] c;
      frm.delete();
      for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom_range(0, 255)));
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n - 4; i++) begin
         c ^= {24'd0, frm[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
   endtask

   task automatic expect_frame(input int n, input bit bad);
      for (int i = 0; i < n; i++)
         sb.push_back('{data: frm[i], sof: (i == 0), eof: (i == n - 1), err: (bad && (i == n - 1))});
   endtask

   task automatic drive_nib(input logic [3:0] d, input logic dv, input logic er);
      @(negedge clk);
      e_rx_d  = d;
      e_rx_dv = dv;
      e_rx_er = er;
   endtask

   task automatic send_preamble();
      for (int i = 0; i < 15; i++) drive_nib(4'h5, 1'b1, 1'b0);
      drive_nib(4'hD, 1'b1, 1'b0);
   endtask

   task automatic send_frame(input int er_nib, input bit odd);
      send_preamble();
      for (int i = 0; i < frm.size(); i++) begin
         drive_nib(frm[i][3:0], 1'b1, er_nib == 2*i);
         drive_nib(frm[i][7:4], 1'b1, er_nib == 2*i + 1);
      end
      if (odd) drive_nib(4'hA, 1'b1, 1'b0);
      drive_nib(4'h0, 1'b0, 1'b0);
   endtask

   task automatic finish_frame(input string tag);
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      check({tag, "_drain"}, sb.size(), 32'd0);
      repeat (3) @(negedge clk);
      check({tag, "_good"}, {16'd0, rx_frame_cnt}, exp_good);
      check({tag, "_bad"},  {16'd0, rx_err_cnt},   exp_bad);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
      check({tag, "_data"},  {24'd0, rx_data},  32'd0);
      check({tag, "_sof"},   {31'd0, rx_sof},   32'd0);
      check({tag, "_eof"},   {31'd0, rx_eof},   32'd0);
      check({tag, "_err"},   {31'd0, rx_err},   32'd0);
      check({tag, "_fcnt"},  {16'd0, rx_frame_cnt}, 32'd0);
      check({tag, "_ecnt"},  {16'd0, rx_err_cnt},   32'd0);
   endtask

   initial begin
      #1 reset = 1'b1;
      #5 check_idle_outputs("por");
      @(negedge clk);
      @(negedge clk) reset = 1'b0;

      build_frame(64); expect_frame(64, 1'b0); exp_good++;
      send_frame(-1, 1'b0); finish_frame("good64");

      build_frame(64); frm[19] ^= 8'h01; expect_frame(64, 1'b1); exp_bad++;
      send_frame(-1, 1'b0); finish_frame("crcbad");

      build_frame(64); expect_frame(64, 1'b1); exp_bad++;
      send_frame(60, 1'b0); finish_frame("rxer");

      build_frame(64); expect_frame(64, 1'b1); exp_bad++;
      send_frame(-1, 1'b1); finish_frame("odd");

      build_frame(63); expect_frame(63, 1'b1); exp_bad++;
      send_frame(-1, 1'b0); finish_frame("short");

      send_preamble(); drive_nib(4'h0, 1'b0, 1'b0); exp_bad++;
      finish_frame("zero");

      // back-to-back frames with a single dv-low cycle between them
      build_frame(65); expect_frame(65, 1'b0); exp_good++;
      send_frame(-1, 1'b0);
      build_frame(200); expect_frame(200, 1'b0); exp_good++;
      send_frame(-1, 1'b0); finish_frame("b2b_frames");

      build_frame(1518); expect_frame(1518, 1'b0); exp_good++;
      send_frame(-1, 1'b0); finish_frame("max");

      build_frame(1600); expect_frame(1519, 1'b1); exp_bad++;
      send_frame(-1, 1'b0); finish_frame("ovf");

      for (int i = 0; i < 3; i++) drive_nib(4'h5, 1'b1, 1'b0);
      drive_nib(4'h3, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) drive_nib(4'h5, 1'b1, 1'b0);
      drive_nib(4'hD, 1'b1, 1'b0);
      for (int i = 0; i < 30; i++) drive_nib(4'($urandom_range(0, 15)), 1'b1, 1'b0);
      drive_nib(4'h0, 1'b0, 1'b0);
      build_frame(64); expect_frame(64, 1'b0); exp_good++;
      send_frame(-1, 1'b0); finish_frame("badpre");

      ign = 1'b1; ign_eof = 0;
      build_frame(64);
      send_preamble();
      for (int i = 0; i < 29; i++) begin
         drive_nib(frm[i][3:0], 1'b1, 1'b0);
         drive_nib(frm[i][7:4], 1'b1, 1'b0);
      end
      drive_nib(frm[29][3:0], 1'b1, 1'b0);
      #5 reset = 1'b1;
      #1 check_idle_outputs("midrst");
      drive_nib(frm[29][7:4], 1'b1, 1'b0);
      for (int i = 30; i < 64; i++) begin
         drive_nib(frm[i][3:0], 1'b1, 1'b0);
         if (i == 31) reset = 1'b0;
         drive_nib(frm[i][7:4], 1'b1, 1'b0);
      end
      drive_nib(4'h0, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      ign = 1'b0;
      check("rst_no_eof", ign_eof, 32'd0);
      exp_good = 0; exp_bad = 0;
      build_frame(64); expect_frame(64, 1'b0); exp_good++;
      send_frame(-1, 1'b0); finish_frame("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
